// File: rtl/asap_pkg.sv
// Shared constants for bus-attached registers: default width and count-limit modes.
package asap_pkg;

   localparam int unsigned WIDTH_DEFAULT = 8;
   localparam int unsigned MODE_WRAP     = 0;
   localparam int unsigned MODE_SAT      = 1;

endpackage

// File: rtl/bus_driver.sv
// Tristate driver placing a register value onto a shared bus while oe is high.
module bus_driver #(
   parameter int unsigned WIDTH = asap_pkg::WIDTH_DEFAULT
) (
   input  logic             oe,
   input  logic [WIDTH-1:0] data,
   inout  wire  [WIDTH-1:0] bus
);

   assign bus = oe ? data : {WIDTH{1'bz}};

endmodule

// File: rtl/register_counter_param.sv
// Bus-attached register that can load from the bus, drive it, and count up or down
// with wrap or clamp at its limits; state changes on the falling clock edge.
module register_counter_param
   import asap_pkg::*;
#(
   parameter int unsigned WIDTH       = WIDTH_DEFAULT,
   parameter int unsigned SATURATE    = MODE_WRAP,
   parameter logic [31:0] RESET_VALUE = 32'h0
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             ie,
   input  logic             oe,
   input  logic             step,
   input  logic             down,
   output logic [WIDTH-1:0] data,
   inout  wire  [WIDTH-1:0] bus,
   output logic             carry,
   output logic             zero
);

   localparam logic [WIDTH-1:0] RST_VAL = RESET_VALUE[WIDTH-1:0];
   localparam logic [WIDTH-1:0] ONE     = {{(WIDTH-1){1'b0}}, 1'b1};
   localparam bit               SAT_EN  = (SATURATE == MODE_SAT);

   logic [WIDTH-1:0] r_data  = RST_VAL;
   logic             r_carry = 1'b0;

   logic             w_at_limit;
   logic [WIDTH-1:0] w_next_count;

   always_comb begin
      w_at_limit   = down ? (r_data == '0) : (r_data == '1);
      w_next_count = down ? (r_data - ONE) : (r_data + ONE);
   end

   // Carry flags the step that hits a limit, whether it wrapped or was clamped.
   always_ff @(negedge clk) begin
      if (rst) begin
         r_data  <= RST_VAL;
         r_carry <= 1'b0;
      end else if (ie) begin
         r_data  <= bus;
         r_carry <= 1'b0;
      end else if (step) begin
         r_carry <= w_at_limit;
         if (!(SAT_EN && w_at_limit)) begin
            r_data <= w_next_count;
         end
      end else begin
         r_carry <= 1'b0;
      end
   end

   assign data  = r_data;
   assign carry = r_carry;
   assign zero  = (r_data == '0);

   bus_driver #(
      .WIDTH (WIDTH)
   ) u_bus_driver (
      .oe   (oe),
      .data (r_data),
      .bus  (bus)
   );

endmodule

// File: tb/tb_register_counter_param.sv
// Directed bench: vector table on an 8-bit wrapping register, hand sequences for clamp
// behaviour and a wrap sweep across 2, 8 and 16-bit instances.
module tb_register_counter_param;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        ie = 1'b0;
   logic        oe = 1'b0;
   logic        step = 1'b0;
   logic        down = 1'b0;
   logic        drv_en = 1'b0;
   logic [15:0] drv_val = 16'h0;

   wire  [7:0]  bus8;
   wire  [3:0]  bus4;
   wire  [1:0]  bus2;
   wire  [15:0] bus16;
   logic [7:0]  d8;
   logic [3:0]  d4;
   logic [1:0]  d2;
   logic [15:0] d16;
   logic        c8, c4, c2, c16;
   logic        z8, z4, z2, z16;

   int n_checks = 0;
   int n_pass   = 0;

   assign bus8  = drv_en ? drv_val[7:0]  : 8'bz;
   assign bus4  = drv_en ? drv_val[3:0]  : 4'bz;
   assign bus2  = drv_en ? drv_val[1:0]  : 2'bz;
   assign bus16 = drv_en ? drv_val       : 16'bz;

   always #5 clk = ~clk;

   register_counter_param #(.WIDTH(8), .SATURATE(0), .RESET_VALUE(32'h80)) u_w8 (
      .clk(clk), .rst(rst), .ie(ie), .oe(oe), .step(step), .down(down),
      .data(d8), .bus(bus8), .carry(c8), .zero(z8));

   register_counter_param #(.WIDTH(4), .SATURATE(1), .RESET_VALUE(32'h0)) u_w4 (
      .clk(clk), .rst(rst), .ie(ie), .oe(oe), .step(step), .down(down),
      .data(d4), .bus(bus4), .carry(c4), .zero(z4));

   register_counter_param #(.WIDTH(2), .SATURATE(0), .RESET_VALUE(32'h0)) u_w2 (
      .clk(clk), .rst(rst), .ie(ie), .oe(oe), .step(step), .down(down),
      .data(d2), .bus(bus2), .carry(c2), .zero(z2));

   register_counter_param #(.WIDTH(16), .SATURATE(0), .RESET_VALUE(32'h0)) u_w16 (
      .clk(clk), .rst(rst), .ie(ie), .oe(oe), .step(step), .down(down),
      .data(d16), .bus(bus16), .carry(c16), .zero(z16));

   typedef struct {
      logic       rst_v;
      logic       ie_v;
      logic       oe_v;
      logic       step_v;
      logic       down_v;
      logic       drv_v;
      logic [7:0] bus_v;
      logic [7:0] exp_data;
      logic       exp_carry;
   } vec_t;

   vec_t vecs [0:20];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
   endtask

   // Inputs change just after a falling edge; outputs are read 1 time unit after the next one.
   task automatic apply(input logic r, input logic i, input logic o, input logic s,
                        input logic d, input logic dv, input logic [15:0] bv);
      rst = r; ie = i; oe = o; step = s; down = d; drv_en = dv; drv_val = bv;
      @(negedge clk);
      #1;
   endtask

   initial begin
      int pulses;

      //             rst  ie   oe   step down drv  bus    data   carry
      vecs[0]  = '{1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,8'h00,8'h80,1'b0};
      vecs[1]  = '{1'b0,1'b1,1'b0,1'b0,1'b0,1'b1,8'hA5,8'hA5,1'b0};
      vecs[2]  = '{1'b0,1'b0,1'b1,1'b0,1'b0,1'b0,8'h00,8'hA5,1'b0};
      vecs[3]  = '{1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,8'h5A,8'hA5,1'b0};
      vecs[4]  = '{1'b0,1'b1,1'b0,1'b0,1'b0,1'b1,8'hFE,8'hFE,1'b0};
      vecs[5]  = '{1'b0,1'b0,1'b0,1'b1,1'b0,1'b0,8'h00,8'hFF,1'b0};
      vecs[6]  = '{1'b0,1'b0,1'b0,1'b1,1'b0,1'b0,8'h00,8'h00,1'b1};
      vecs[7]  = '{1'b0,1'b0,1'b0,1'b1,1'b0,1'b0,8'h00,8'h01,1'b0};
      vecs[8]  = '{1'b0,1'b1,1'b0,1'b0,1'b0,1'b1,8'h10,8'h10,1'b0};
      vecs[9]  = '{1'b0,1'b1,1'b0,1'b1,1'b0,1'b1,8'h33,8'h33,1'b0};
      vecs[10] = '{1'b0,1'b1,1'b1,1'b0,1'b0,1'b0,8'h00,8'h33,1'b0};
      vecs[11] = '{1'b0,1'b0,1'b0,1'b1,1'b0,1'b0,8'h00,8'h34,1'b0};
      vecs[12] = '{1'b1,1'b1,1'b0,1'b1,1'b0,1'b1,8'h55,8'h80,1'b0};
      vecs[13] = '{1'b0,1'b0,1'b0,1'b1,1'b0,1'b0,8'h00,8'h81,1'b0};
      vecs[14] = '{1'b0,1'b1,1'b0,1'b0,1'b0,1'b1,8'hFF,8'hFF,1'b0};
      vecs[15] = '{1'b0,1'b0,1'b0,1'b1,1'b0,1'b0,8'h00,8'h00,1'b1};
      vecs[16] = '{1'b0,1'b1,1'b0,1'b1,1'b0,1'b1,8'h07,8'h07,1'b0};
      vecs[17] = '{1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,8'h00,8'h07,1'b0};
      vecs[18] = '{1'b0,1'b0,1'b0,1'b1,1'b1,1'b0,8'h00,8'h06,1'b0};
      vecs[19] = '{1'b0,1'b1,1'b0,1'b0,1'b0,1'b1,8'h00,8'h00,1'b0};
      vecs[20] = '{1'b0,1'b0,1'b0,1'b1,1'b1,1'b0,8'h00,8'hFF,1'b1};

      // Power-up state before any clock edge.
      #1;
      check("init_data", {24'h0, d8}, 32'h80);
      check("init_carry", {31'h0, c8}, 32'h0);
      check("init_zero4", {31'h0, z4}, 32'h1);

      for (int k = 0; k < 21; k++) begin
         apply(vecs[k].rst_v, vecs[k].ie_v, vecs[k].oe_v, vecs[k].step_v, vecs[k].down_v,
               vecs[k].drv_v, {8'h00, vecs[k].bus_v});
         check($sformatf("v%0d_data", k), {24'h0, d8}, {24'h0, vecs[k].exp_data});
         check($sformatf("v%0d_carry", k), {31'h0, c8}, {31'h0, vecs[k].exp_carry});
         check($sformatf("v%0d_zero", k), {31'h0, z8}, {31'h0, (vecs[k].exp_data == 8'h00)});
         if (vecs[k].oe_v)
            check($sformatf("v%0d_bus_driven", k), {24'h0, bus8}, {24'h0, vecs[k].exp_data});
         else if (vecs[k].drv_v)
            check($sformatf("v%0d_bus_released", k), {24'h0, bus8}, {24'h0, vecs[k].bus_v});
      end

      // Clamp at zero on the saturating 4-bit register.
      apply(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0);
      check("sat_reset", {28'h0, d4}, 32'h0);
      apply(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 16'h1);
      check("sat_load", {28'h0, d4}, 32'h1);
      apply(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 16'h0);
      check("sat_dn1_data", {28'h0, d4}, 32'h0);
      check("sat_dn1_carry", {31'h0, c4}, 32'h0);
      check("sat_dn1_zero", {31'h0, z4}, 32'h1);
      apply(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 16'h0);
      check("sat_dn2_data", {28'h0, d4}, 32'h0);
      check("sat_dn2_carry", {31'h0, c4}, 32'h1);
      apply(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 16'h0);
      check("sat_dn3_data", {28'h0, d4}, 32'h0);
      check("sat_dn3_carry", {31'h0, c4}, 32'h1);
      apply(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 16'hF);
      apply(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 16'h0);
      check("sat_up_data", {28'h0, d4}, 32'hF);
      check("sat_up_carry", {31'h0, c4}, 32'h1);
      apply(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0);
      check("sat_idle_carry", {31'h0, c4}, 32'h0);

      // Wrap sweeps: 2^W + 1 up-steps from zero land on 1 with a single carry pulse.
      apply(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 16'h0);
      pulses = 0;
      for (int k = 0; k < 5; k++) begin
         apply(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 16'h0);
         pulses += int'(c2);
      end
      check("sweep2_data", {30'h0, d2}, 32'h1);
      check("sweep2_pulses", pulses, 32'd1);

      apply(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 16'h0);
      pulses = 0;
      for (int k = 0; k < 257; k++) begin
         apply(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 16'h0);
         pulses += int'(c8);
      end
      check("sweep8_data", {24'h0, d8}, 32'h1);
      check("sweep8_pulses", pulses, 32'd1);

      apply(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 16'h0);
      check("sweep16_start_zero", {31'h0, z16}, 32'h1);
      pulses = 0;
      for (int k = 0; k < 65537; k++) begin
         apply(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 16'h0);
         pulses += int'(c16);
      end
      check("sweep16_data", {16'h0, d16}, 32'h1);
      check("sweep16_pulses", pulses, 32'd1);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/register_counter_param.md
REGISTER_COUNTER_PARAM -- requirements
Module: register_counter_param

Interface
REQ-001 Parameter WIDTH, default 8, sets the register and bus width in bits (legal 2..32).
REQ-002 Parameter SATURATE, default 0; 0 means the count wraps at its limits, 1 means it clamps at its limits.
REQ-003 Parameter RESET_VALUE, default 0, is the register value after reset, truncated to WIDTH bits.
REQ-004 The block has one clock, clk; rst is synchronous and active-high.
REQ-005 Port clk, input, width 1: clock; all state updates on its falling edge.
REQ-006 Port rst, input, width 1: synchronous, active-high reset.
REQ-007 Port ie, input, width 1: load the register from bus.
REQ-008 Port oe, input, width 1: drive data onto bus.
REQ-009 Port step, input, width 1: count enable.
REQ-010 Port down, input, width 1: count direction; 0 means +1, 1 means -1.
REQ-011 Port data, output, width WIDTH: current register value.
REQ-012 Port bus, inout, width WIDTH: shared system bus.
REQ-013 Port carry, output, width 1: registered one-cycle limit-event flag.
REQ-014 Port zero, output, width 1: high when data equals 0.

Function
REQ-015 bus SHALL be driven with data while oe=1 and SHALL be high-impedance while oe=0, purely combinationally.
REQ-016 At each falling clk edge the register update SHALL follow this priority: rst, then ie, then step, otherwise hold.
- rst: data becomes RESET_VALUE.
- ie: data becomes bus.
- step: data counts by one in the direction given by down.
- none of these: data holds.
REQ-017 When ie=1 and step=1 in the same cycle, the load SHALL win and no count SHALL occur.
REQ-018 When ie=1 and oe=1 in the same cycle, the register SHALL reload its own value, leaving data unchanged.
REQ-019 Counting arithmetic SHALL be modulo 2^WIDTH with no widening of data.
REQ-020 With SATURATE=0, up-count from all-ones SHALL give 0, and down-count from 0 SHALL give all-ones.
REQ-021 With SATURATE=1, up-count at all-ones and down-count at 0 SHALL leave data unchanged.
REQ-022 carry SHALL be set for exactly the cycle after a step that hits a limit (a wrap, or an attempted move past a clamp) and SHALL be cleared on every other edge.
REQ-023 A load or a reset SHALL clear carry.
REQ-024 zero SHALL equal (data == 0) combinationally, with no added latency.
REQ-025 Latency SHALL be one falling edge from any control input to data and carry.

Reset
REQ-026 On reset: data = RESET_VALUE, carry = 0, and zero follows data.
REQ-027 rst asserted mid-count SHALL override ie and step on that same edge.
REQ-028 bus behaviour SHALL depend on oe only, independent of rst.
REQ-029 The initial simulation value of data SHALL be RESET_VALUE and of carry SHALL be 0.

Structure
REQ-030 The shared package (asap_pkg) SHALL hold the WIDTH default (8) and the mode constants MODE_WRAP=0 and MODE_SAT=1.
REQ-031 The tristate bus driver SHALL be a separate sub-module, bus_driver (parameters: WIDTH; ports: oe, data, bus), reusable by all bus-attached registers.
REQ-032 The count/limit logic SHALL be a single always block on the falling edge of clk.

Verification
REQ-033 Load-and-drive test, WIDTH=8, SATURATE=0: drive bus=0xA5 with ie=1 for one edge, then set oe=1 -> data=0xA5 and bus reads 0xA5; with oe=0 -> bus is Z.
REQ-034 Up-wrap test, WIDTH=8, SATURATE=0: load 0xFE, then step=1, down=0 for 3 edges -> data goes 0xFF, 0x00, 0x01; carry is high only after the 0x00 edge; zero is high only while data=0x00.
REQ-035 Down-saturate test, WIDTH=4, SATURATE=1: load 0x1, then step=1, down=1 for 3 edges -> data goes 0x0, 0x0, 0x0; carry is high after the 2nd and 3rd edges.
REQ-036 Load-priority test: load 0x10, then ie=1 with step=1 and bus=0x33 -> data=0x33 with no increment; with ie=1 and oe=1 -> data is unchanged.
REQ-037 Reset-priority test, RESET_VALUE=0x80: counting with ie=1 and rst=1 on the same edge -> data=0x80 and carry=0; the next step gives 0x81.
REQ-038 Width sweep: WIDTH in {2, 8, 16}, counting up 2^WIDTH+1 steps from 0 -> data=1, with exactly one carry pulse.
